// File: rtl/match_ctrl.sv
// Match-level controller: scores physics rally results, freezes the scene for a
// serve pause between rallies and gates the physics frame trigger.
module match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       phys_en,
  output logic [1:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] match_winner,
  output logic [7:0] serve_left,
  output logic       point_pulse
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE      = 2'd1,
    PLAY       = 2'd2,
    MATCH_OVER = 2'd3
  } state_e;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [3:0] WIN_LOAD   = 4'(WIN_SCORE);

  state_e     state_q;
  logic [1:0] sync_q;
  logic       start_q;
  logic       go_q;
  logic [3:0] p1_q;
  logic [3:0] p2_q;
  logic [1:0] winner_q;
  logic [7:0] serve_left_q;
  logic       point_q;

  logic       start_rise;
  logic       go_rise;
  logic [3:0] p1_inc;
  logic [3:0] p2_inc;

  assign start_rise = sync_q[1] & ~start_q;
  assign go_rise    = game_over & ~go_q;

  // Saturating increments keep the 4-bit scores from wrapping at 15.
  assign p1_inc = (p1_q == 4'hF) ? p1_q : p1_q + 4'd1;
  assign p2_inc = (p2_q == 4'hF) ? p2_q : p2_q + 4'd1;

  // NOTE: every register, including the synchronizer, is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= 2'b00;
      start_q      <= 1'b0;
      go_q         <= 1'b0;
      p1_q         <= 4'd0;
      p2_q         <= 4'd0;
      winner_q     <= 2'd0;
      serve_left_q <= 8'd0;
      point_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sync_q  <= {sync_q[0], start_btn};
      start_q <= sync_q[1];
      go_q    <= game_over;
      point_q <= 1'b0;

      case (state_q)
        IDLE, MATCH_OVER: begin
          if (start_rise) begin
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            winner_q     <= 2'd0;
            serve_left_q <= SERVE_LOAD;
            state_q      <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (serve_left_q <= 8'd1) begin
              serve_left_q <= 8'd0;
              state_q      <= PLAY;
            end else begin
              serve_left_q <= serve_left_q - 8'd1;
            end
          end
        end
        PLAY: begin
          if (go_rise) begin
            serve_left_q <= SERVE_LOAD;
            state_q      <= SERVE;
            if (winner == 2'd1) begin
              p1_q    <= p1_inc;
              point_q <= 1'b1;
              if (p1_inc == WIN_LOAD) begin
                winner_q     <= 2'd1;
                serve_left_q <= 8'd0;
                state_q      <= MATCH_OVER;
              end
            end else if (winner == 2'd2) begin
              p2_q    <= p2_inc;
              point_q <= 1'b1;
              if (p2_inc == WIN_LOAD) begin
                winner_q     <= 2'd2;
                serve_left_q <= 8'd0;
                state_q      <= MATCH_OVER;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phys_en      = frame_tick & (state_q == PLAY);
  assign state        = state_q;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign match_winner = winner_q;
  assign serve_left   = serve_left_q;
  assign point_pulse  = point_q;

endmodule
